// File: rtl/led_pwm_tick_gen.sv
// Prescaler for the LED PWM block: emits a single-cycle tick once every
// (i_div + 1) enabled clock cycles.
module tick_gen #(
    parameter int DIV_BITS = 4
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_en,
    input  logic [DIV_BITS-1:0] i_div,
    output logic                tick
);

    logic [DIV_BITS-1:0] p;
    logic                at_limit;

    // A ">=" comparison rather than "==" means that lowering i_div below the
    // current p still produces a tick on the very next enabled cycle.
    assign at_limit = (p >= i_div);
    assign tick     = i_en & ~i_rst & at_limit;

    // Prescale counter: wraps to zero on each tick and holds while disabled.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            p <= '0;
        end else if (i_en) begin
            if (at_limit) begin
                p <= '0;
            end else begin
                p <= p + 1'b1;
            end
        end
    end

endmodule

// File: rtl/led_pwm.sv
// Multi-channel LED PWM generator with a shared period counter and
// double-buffered duty registers. New duty values land in a shadow register
// and only become active at the period wrap, so no channel ever shows a
// truncated or stretched pulse.
module led_pwm #(
    parameter int CHANNELS = 3,
    parameter int WIDTH    = 8,
    parameter int DIV_BITS = 4,
    localparam int ADDR_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_en,
    input  logic [DIV_BITS-1:0] i_div,
    input  logic                i_wr,
    input  logic [ADDR_W-1:0]   i_addr,
    input  logic [WIDTH-1:0]    i_duty,
    output logic [CHANNELS-1:0] o_pwm,
    output logic                o_period,
    output logic [WIDTH-1:0]    o_count
);

    localparam logic [WIDTH-1:0]  MAX_COUNT = '1;
    localparam logic [ADDR_W:0]   ADDR_LIM  = (ADDR_W + 1)'(CHANNELS);

    logic                tick;
    logic                wrap;
    logic                addr_ok;
    logic [CHANNELS-1:0] write_hit;
    logic [WIDTH-1:0]    shadow [CHANNELS];
    logic [WIDTH-1:0]    active [CHANNELS];

    tick_gen #(
        .DIV_BITS (DIV_BITS)
    ) u_tick_gen (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_en  (i_en),
        .i_div (i_div),
        .tick  (tick)
    );

    // The extra leading zero lets the range check work even when CHANNELS
    // is an exact power of two and the limit does not fit in ADDR_W bits.
    assign addr_ok = ({1'b0, i_addr} < ADDR_LIM);
    assign wrap    = tick && (o_count == MAX_COUNT);

    // One-hot decode of the write strobe; out-of-range addresses hit nothing.
    always_comb begin
        write_hit = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            write_hit[k] = i_wr && addr_ok && (i_addr == ADDR_W'(k));
        end
    end

    // Period counter advances on each prescaler tick and flags the wrap one cycle later.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_count  <= '0;
            o_period <= 1'b0;
        end else begin
            if (tick) begin
                o_count <= o_count + 1'b1;
            end
            o_period <= wrap;
        end
    end

    // Shadow/active duty registers; a write landing on the wrap bypasses the shadow.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int k = 0; k < CHANNELS; k++) begin
                shadow[k] <= '0;
                active[k] <= '0;
            end
        end else begin
            for (int k = 0; k < CHANNELS; k++) begin
                if (write_hit[k]) begin
                    shadow[k] <= i_duty;
                end
                if (wrap) begin
                    if (write_hit[k]) begin
                        active[k] <= i_duty;
                    end else begin
                        active[k] <= shadow[k];
                    end
                end
            end
        end
    end

    // Registered compare of the period counter against each active duty.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_pwm <= '0;
        end else begin
            for (int k = 0; k < CHANNELS; k++) begin
                o_pwm[k] <= (o_count < active[k]);
            end
        end
    end

endmodule

// File: tb/tb_led_pwm.sv
// Testbench for led_pwm (CHANNELS=3, WIDTH=4, DIV_BITS=2). The stimulus
// process queues the expected shape of whole PWM periods; a monitor measures
// each period between o_period pulses and checks it against the queue.
module tb_led_pwm;

    localparam int CHANNELS = 3;
    localparam int WIDTH    = 4;
    localparam int DIV_BITS = 2;
    localparam int ADDR_W   = 2;

    logic                i_clk = 1'b0;
    logic                i_rst;
    logic                i_en;
    logic [DIV_BITS-1:0] i_div;
    logic                i_wr;
    logic [ADDR_W-1:0]   i_addr;
    logic [WIDTH-1:0]    i_duty;
    logic [CHANNELS-1:0] o_pwm;
    logic                o_period;
    logic [WIDTH-1:0]    o_count;

    typedef struct {
        int win;
        int len;
        int h0;
        int h1;
        int h2;
    } exp_t;

    exp_t exp_q [$];
    int   tests   = 0;
    int   fails   = 0;
    int   cur_win = 0;

    always #5 i_clk = ~i_clk;

    led_pwm #(
        .CHANNELS (CHANNELS),
        .WIDTH    (WIDTH),
        .DIV_BITS (DIV_BITS)
    ) dut (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_en     (i_en),
        .i_div    (i_div),
        .i_wr     (i_wr),
        .i_addr   (i_addr),
        .i_duty   (i_duty),
        .o_pwm    (o_pwm),
        .o_period (o_period),
        .o_count  (o_count)
    );

    // Single comparison point; every check in the bench goes through here.
    task automatic checkOutput(input string name, input int actual, input int expected);
        tests++;
        if (actual != expected) begin
            fails++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    // Lets the monitor process the current cycle before the stimulus reads cur_win.
    task automatic syncMon();
        @(negedge i_clk);
        #1;
    endtask

    // One-cycle duty write.
    task automatic applyStimulus(input logic [ADDR_W-1:0] addr, input logic [WIDTH-1:0] duty);
        i_wr   = 1'b1;
        i_addr = addr;
        i_duty = duty;
        step();
        i_wr   = 1'b0;
    endtask

    task automatic expectWindow(input int offset, input int len, input int h0, input int h1, input int h2);
        exp_t e;
        e.win = cur_win + offset;
        e.len = len;
        e.h0  = h0;
        e.h1  = h1;
        e.h2  = h2;
        exp_q.push_back(e);
    endtask

    task automatic waitPulse(input string name);
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (o_period !== 1'b1 && n < 200);
        checkOutput(name, int'(o_period === 1'b1), 1);
    endtask

    task automatic waitCount(input string name, input int value);
        int n;
        n = 0;
        while (int'(o_count) != value && n < 200) begin
            step();
            n++;
        end
        checkOutput(name, int'(o_count), value);
    endtask

    // Monitor: measures length and per-channel high time of each period.
    initial begin
        int   len;
        int   hi [CHANNELS];
        bit   valid;
        exp_t e;
        len   = 0;
        valid = 1'b0;
        for (int k = 0; k < CHANNELS; k++) hi[k] = 0;
        forever begin
            @(negedge i_clk);
            if (i_rst) begin
                valid = 1'b0;
                len   = 0;
                for (int k = 0; k < CHANNELS; k++) hi[k] = 0;
            end else begin
                if (o_period) begin
                    while (exp_q.size() > 0 && exp_q[0].win < cur_win) begin
                        e = exp_q.pop_front();
                        checkOutput("window skipped", e.win, cur_win);
                    end
                    if (exp_q.size() > 0 && exp_q[0].win == cur_win) begin
                        e = exp_q.pop_front();
                        checkOutput("window valid", int'(valid), 1);
                        checkOutput("period spacing", len, e.len);
                        checkOutput("ch0 high", hi[0], e.h0);
                        checkOutput("ch1 high", hi[1], e.h1);
                        checkOutput("ch2 high", hi[2], e.h2);
                    end
                    cur_win++;
                    len   = 0;
                    valid = 1'b1;
                    for (int k = 0; k < CHANNELS; k++) hi[k] = 0;
                end
                len++;
                for (int k = 0; k < CHANNELS; k++) hi[k] += int'(o_pwm[k]);
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed stimulus.
    initial begin
        int c0;
        int c1;
        int n;

        i_rst  = 1'b1;
        i_en   = 1'b0;
        i_div  = '0;
        i_wr   = 1'b0;
        i_addr = '0;
        i_duty = '0;
        step();
        step();
        checkOutput("reset pwm", int'(o_pwm), 0);
        checkOutput("reset count", int'(o_count), 0);
        checkOutput("reset period", int'(o_period), 0);
        i_rst = 1'b0;
        i_en  = 1'b1;
        step();
        checkOutput("count starts", int'(o_count), 1);

        // Duty 0/8/15 at i_div=0.
        applyStimulus(2'd0, 4'd0);
        applyStimulus(2'd1, 4'd8);
        applyStimulus(2'd2, 4'd15);
        waitPulse("duty wrap");
        syncMon();
        expectWindow(0, 16, 0, 8, 15);
        expectWindow(1, 16, 0, 8, 15);
        waitPulse("duty period 1");
        waitPulse("duty period 2");

        // Mid-period write stays in the shadow until the wrap.
        waitCount("reach count 5", 5);
        applyStimulus(2'd1, 4'd4);
        syncMon();
        expectWindow(0, 16, 0, 8, 15);
        expectWindow(1, 16, 0, 4, 15);
        waitPulse("shadow period 1");
        waitPulse("shadow period 2");

        // Write on the wrap tick goes straight to the active register.
        waitCount("reach count 15", 15);
        applyStimulus(2'd1, 4'd12);
        checkOutput("bypass wrap pulse", int'(o_period), 1);
        syncMon();
        expectWindow(0, 16, 0, 12, 15);
        waitPulse("bypass period");

        // Enable low freezes counter and outputs.
        waitCount("reach count 6", 6);
        checkOutput("pre-freeze pwm", int'(o_pwm), 6);
        i_en = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            checkOutput("frozen count", int'(o_count), 6);
            checkOutput("frozen pwm", int'(o_pwm), 6);
            checkOutput("frozen period", int'(o_period), 0);
        end
        i_en = 1'b1;
        applyStimulus(2'd3, 4'd1);
        waitPulse("bad addr wrap");
        syncMon();
        expectWindow(0, 16, 0, 12, 15);
        waitPulse("bad addr period");

        // Prescale by 3.
        i_div = 2'd2;
        waitPulse("prescale wrap");
        syncMon();
        expectWindow(0, 48, 0, 36, 45);
        checkOutput("prescale count t0", int'(o_count), 0);
        step();
        checkOutput("prescale count t1", int'(o_count), 0);
        step();
        checkOutput("prescale count t2", int'(o_count), 0);
        step();
        checkOutput("prescale count t3", int'(o_count), 1);
        waitPulse("prescale period");

        // Lowering i_div below p ticks on the next cycle.
        i_div = 2'd3;
        c0 = int'(o_count);
        n  = 0;
        while (int'(o_count) == c0 && n < 10) begin
            step();
            n++;
        end
        checkOutput("div3 tick seen", int'(int'(o_count) != c0), 1);
        c1 = int'(o_count);
        step();
        step();
        checkOutput("div3 no tick", int'(o_count), c1);
        i_div = 2'd1;
        step();
        checkOutput("div 3->1 tick", int'(o_count), (c1 + 1) % 16);

        // Reset mid-run discards duties and restarts the count.
        i_div = 2'd0;
        waitCount("reach count 7", 7);
        checkOutput("pre-reset pwm", int'(o_pwm), 6);
        i_rst = 1'b1;
        step();
        checkOutput("mid reset pwm", int'(o_pwm), 0);
        checkOutput("mid reset count", int'(o_count), 0);
        checkOutput("mid reset period", int'(o_period), 0);
        step();
        i_rst = 1'b0;
        checkOutput("post reset count", int'(o_count), 0);
        step();
        checkOutput("restart count", int'(o_count), 1);
        waitPulse("post reset wrap");
        syncMon();
        expectWindow(0, 16, 0, 0, 0);
        waitPulse("post reset period");
        syncMon();

        checkOutput("scoreboard drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
